// File: rtl/median_sort_engine_pkg.sv
// Shared constants and state type for the median filter sort engine.
package median_sort_engine_pkg;

   localparam int unsigned MF_WINDOW_SIZE = 9;
   localparam int unsigned MF_MEDIAN_IDX  = 4;
   localparam int unsigned MF_DATA_WIDTH  = 8;
   localparam int unsigned MF_SORT_CYCLES = 36;

   typedef enum logic {
      StIdle,
      StSort
   } mf_state_e;

endpackage

// File: rtl/median_sort_engine_cmp_swap.sv
// Combinational compare-swap: orders two unsigned values; equal inputs pass through unswapped.
module median_sort_engine_cmp_swap
   import median_sort_engine_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = MF_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] lo_o,
   output logic [DATA_WIDTH-1:0] hi_o
);

   logic swap;

   assign swap = a_i > b_i;
   assign lo_o = swap ? b_i : a_i;
   assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/median_sort_engine.sv
// Window buffer plus sequential bubble sort; one compare-swap per clock, median reported on a pulse.
module median_sort_engine
   import median_sort_engine_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = MF_DATA_WIDTH,
   parameter int unsigned WINDOW_SIZE = MF_WINDOW_SIZE,
   parameter int unsigned MEDIAN_IDX  = MF_MEDIAN_IDX
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  wr_en,
   input  logic [3:0]            wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  start_bubble_sort,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] median_out,
   output logic                  median_valid
);

   localparam logic [3:0] LastAddr = 4'(WINDOW_SIZE - 1);
   // Highest pass index; also the highest j in pass 0.
   localparam logic [2:0] LastPass = 3'(WINDOW_SIZE - 2);

   mf_state_e             state_q, state_d;
   logic [2:0]            pass_q, pass_d;
   logic [2:0]            j_q, j_d;
   logic [DATA_WIDTH-1:0] win_q [WINDOW_SIZE];
   logic [DATA_WIDTH-1:0] win_d [WINDOW_SIZE];
   logic [DATA_WIDTH-1:0] median_q, median_d;
   logic                  valid_q, valid_d;

   logic [3:0]            idx_lo, idx_hi;
   logic [DATA_WIDTH-1:0] cmp_lo, cmp_hi;

   assign idx_lo = {1'b0, j_q};
   assign idx_hi = idx_lo + 4'd1;

   median_sort_engine_cmp_swap #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_cmp_swap (
      .a_i (win_q[idx_lo]),
      .b_i (win_q[idx_hi]),
      .lo_o(cmp_lo),
      .hi_o(cmp_hi)
   );

   always_comb begin
      state_d  = state_q;
      pass_d   = pass_q;
      j_d      = j_q;
      win_d    = win_q;
      median_d = median_q;
      valid_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (wr_en && (wr_addr <= LastAddr)) begin
               win_d[wr_addr] = wr_data;
            end
            if (start_bubble_sort) begin
               state_d = StSort;
               pass_d  = '0;
               j_d     = '0;
            end
         end
         StSort: begin
            win_d[idx_lo] = cmp_lo;
            win_d[idx_hi] = cmp_hi;
            if (j_q == (LastPass - pass_q)) begin
               j_d = '0;
               if (pass_q == LastPass) begin
                  // Median slot settled several passes ago; last compare only touches 0/1.
                  state_d  = StIdle;
                  pass_d   = '0;
                  median_d = win_q[MEDIAN_IDX];
                  valid_d  = 1'b1;
               end else begin
                  pass_d = pass_q + 3'd1;
               end
            end else begin
               j_d = j_q + 3'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= StIdle;
         pass_q   <= '0;
         j_q      <= '0;
         win_q    <= '{default: '0};
         median_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pass_q   <= pass_d;
         j_q      <= j_d;
         win_q    <= win_d;
         median_q <= median_d;
         valid_q  <= valid_d;
      end
   end

   assign busy         = (state_q == StSort);
   assign median_out   = median_q;
   assign median_valid = valid_q;

endmodule

// File: tb/tb_median_sort_engine.sv
// Self-checking bench for median_sort_engine: table vectors, corner sequences, random windows.
module tb_median_sort_engine;

   logic       CLK;
   logic       RST;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       start_bubble_sort;
   logic       busy;
   logic [7:0] median_out;
   logic       median_valid;

   int checks;
   int passes;
   int mbuf [9];

   typedef struct {
      int pix [9];
      int med;
   } vec_t;

   vec_t tbl [4];

   median_sort_engine dut (
      .CLK              (CLK),
      .RST              (RST),
      .wr_en            (wr_en),
      .wr_addr          (wr_addr),
      .wr_data          (wr_data),
      .start_bubble_sort(start_bubble_sort),
      .busy             (busy),
      .median_out       (median_out),
      .median_valid     (median_valid)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // Model: write to the window, ignoring out-of-range addresses.
   task automatic wr(input int a, input int d);
      wr_en   = 1'b1;
      wr_addr = a[3:0];
      wr_data = d[7:0];
      @(negedge CLK);
      wr_en = 1'b0;
      if (a < 9) mbuf[a] = d;
   endtask

   // Model: sorting leaves the window in ascending order; median is the middle element.
   function automatic int model_med();
      int q[$];
      foreach (mbuf[i]) q.push_back(mbuf[i]);
      q.sort();
      foreach (mbuf[i]) mbuf[i] = q[i];
      return q[4];
   endfunction

   // Called at a negedge. inj_kind: 1 = start pulse, 2 = write addr 4 = 0, both at negedge inj_k.
   task automatic run_sort(input int exp, input string nm, input int inj_k, input int inj_kind,
                           input bit pre, input bit chain);
      int bcnt, vcnt, vpos, vmed;
      bcnt = 0; vcnt = 0; vpos = -1; vmed = -1;
      start_bubble_sort = 1'b1;
      if (!pre) @(negedge CLK);
      else @(negedge CLK);
      for (int k = 1; k <= 37; k++) begin
         start_bubble_sort = 1'b0;
         wr_en = 1'b0;
         if (k == 1) check({nm, "_busy_rise"}, int'(busy), 1);
         if (busy) bcnt++;
         if (median_valid) begin
            vcnt++;
            vpos = k;
            vmed = int'(median_out);
         end
         if (k == inj_k && inj_kind == 1) start_bubble_sort = 1'b1;
         if (k == inj_k && inj_kind == 2) begin
            wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'd0;
         end
         if (k < 37) @(negedge CLK);
      end
      check({nm, "_busy_cycles"}, bcnt, 36);
      check({nm, "_valid_count"}, vcnt, 1);
      check({nm, "_valid_pos"}, vpos, 37);
      check({nm, "_median"}, vmed, exp);
      if (chain) begin
         start_bubble_sort = 1'b1;
      end else begin
         @(negedge CLK);
         check({nm, "_valid_drop"}, int'(median_valid), 0);
         check({nm, "_median_hold"}, int'(median_out), exp);
      end
   endtask

   task automatic load(input int idx);
      for (int i = 0; i < 9; i++) wr(i, tbl[idx].pix[i]);
   endtask

   initial begin
      int e, n, vc;
      checks = 0; passes = 0;
      foreach (mbuf[i]) mbuf[i] = 0;
      tbl[0].pix = '{1, 2, 3, 4, 5, 6, 7, 8, 9};          tbl[0].med = 5;
      tbl[1].pix = '{9, 8, 7, 6, 5, 4, 3, 2, 1};          tbl[1].med = 5;
      tbl[2].pix = '{7, 7, 7, 0, 0, 255, 255, 3, 7};      tbl[2].med = 7;
      tbl[3].pix = '{50, 10, 90, 30, 70, 20, 80, 40, 60}; tbl[3].med = 50;

      RST = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start_bubble_sort = 1'b0;
      repeat (3) @(negedge CLK);
      check("reset_busy", int'(busy), 0);
      check("reset_valid", int'(median_valid), 0);
      check("reset_median", int'(median_out), 0);
      RST = 1'b1;
      @(negedge CLK);

      // Table vectors.
      for (int t = 0; t < 3; t++) begin
         load(t);
         e = model_med();
         run_sort(tbl[t].med, $sformatf("tbl%0d", t), 0, 0, 1'b0, 1'b0);
      end

      // Write in the start cycle is included; write during sort is ignored.
      load(0);
      e = model_med();
      run_sort(5, "asc_again", 0, 0, 1'b0, 1'b0);
      wr_en = 1'b1; wr_addr = 4'd8; wr_data = 8'd200; mbuf[8] = 200;
      e = model_med();
      run_sort(5, "start_wr", 0, 0, 1'b0, 1'b0);
      check("start_wr_top_kept", mbuf[8], 200);
      run_sort(5, "sort_wr_ignored", 5, 2, 1'b0, 1'b0);

      // Start during busy ignored; out-of-range write ignored.
      run_sort(5, "busy_start", 10, 1, 1'b0, 1'b0);
      wr(12, 0);
      run_sort(model_med(), "addr12", 0, 0, 1'b0, 1'b0);

      // Reset mid-sort.
      start_bubble_sort = 1'b1;
      @(negedge CLK);
      start_bubble_sort = 1'b0;
      repeat (19) @(negedge CLK);
      #2 RST = 1'b0;
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_median", int'(median_out), 0);
      check("rst_valid", int'(median_valid), 0);
      foreach (mbuf[i]) mbuf[i] = 0;
      @(negedge CLK);
      RST = 1'b1;
      vc = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         if (median_valid) vc++;
      end
      check("rst_no_valid", vc, 0);
      load(3);
      e = model_med();
      run_sort(tbl[3].med, "after_rst", 0, 0, 1'b0, 1'b0);

      // Start in the median_valid cycle.
      run_sort(50, "chain1", 0, 0, 1'b0, 1'b1);
      run_sort(50, "chain2", 0, 0, 1'b1, 1'b0);

      // Random windows, partial and out-of-range writes, duplicates.
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(3, 12);
         for (int w = 0; w < n; w++) begin
            wr($urandom_range(0, 15), ($urandom_range(0, 3) == 0) ? 7 : $urandom_range(0, 255));
         end
         e = model_med();
         run_sort(e, $sformatf("rand%0d", it), 0, 0, 1'b0, 1'b0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
